isp_param_ahb_slave: RTL and testbench
======================================

Name: isp_param_ahb_slave

Overview:
AHB-Lite slave that holds the ISP's run-time parameter registers and drives them into the pixel pipeline. It sits directly downstream of the system AHB interconnect and upstream of the ISP datapath. Software-written "staging" values are committed to "active" outputs only on a frame boundary, so the pipeline never sees a mid-frame parameter change.

Parameters:
ADDR_W, 8, number of HADDR LSBs decoded
FCNT_W, 16, width of frame counter readback field (≤16)

Ports:
HCLK  in  1  bus and ISP clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  address; only [ADDR_W-1:0] decoded
HTRANS  in  2  transfer type; NONSEQ/SEQ are valid
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready, always 1
HRESP  out  1  always 0 (OKAY)
frame_start  in  1  one-cycle pulse at start of each frame
isp_en  out  1  ISP enable
param0, param1, param2  out  32 each  active parameter words
frames_cnt  out  FCNT_W  frames seen since reset, wrapping

Behaviour:
- Single clock HCLK; reset is asynchronous, active-low on HRESETn. All flops clear on reset: outputs 0, staging 0, FSM IDLE, frames_cnt 0.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. Address, HWRITE and HSIZE are registered. In the following data phase, HWDATA is written at the clock edge closing that phase.
- Zero wait states: HREADYOUT=1 and HRESP=0 always.
- Register map (word offsets):
  - 0x00 CTRL RW: bit0 isp_en, which is applied immediately. bit1 UPD_REQ, write 1 to arm a frame-synced commit; self-clears when the commit occurs. bit2 FORCE, write 1 to commit on the next cycle; always reads 0.
  - 0x04/0x08/0x0C STG0..2 RW: staging words.
  - 0x10 STATUS RO: bit0 pending; [31:16] frames_cnt zero-extended.
  - 0x14 ACT0 RO: active param0.
- Unmapped offsets read 0, and writes to them are ignored. HADDR[1:0] is ignored for decode.
- HRDATA is combinational from the registered data-phase address and is 0 when no read data phase is in progress. A read issued directly after a write to the same register returns the new value.
- Commit FSM:
  - IDLE --(UPD_REQ written 1)--> PENDING.
  - PENDING --(frame_start)--> COMMIT (1 cycle): param0..2 <= STG0..2, then to IDLE, and UPD_REQ/pending clear.
  - FORCE=1 from any state goes to COMMIT next cycle; PENDING is cancelled.
  - frame_start in IDLE leaves params unchanged.
- Simultaneous events:
  - UPD_REQ written in the same cycle as frame_start: arm only; the commit waits for the next frame_start.
  - STG write in the COMMIT cycle: the old STG value is committed; the new value stays staged.
- frames_cnt increments on each frame_start and wraps 2^FCNT_W-1 -> 0.
- Reset mid-frame or mid-transfer: immediate clear, no commit.

Optional Feature:
ISP_PARAM_BYTE_WR_EN.
- Defined: sub-word writes update only the lanes selected by HSIZE/HADDR[1:0] (byte, halfword, word; little-endian).
- Undefined: every write updates all 32 bits regardless of HSIZE.

Test Plan:
- Reset released, read 0x00–0x14 -> all 0, HREADYOUT=1 throughout.
- Write STG0=0x00000001, STG1=0x23498701, STG2=0xAB9C8F00, CTRL=0x2, no frame_start -> param outputs remain 0, STATUS bit0=1; pulse frame_start -> next cycle param0/1/2 equal the staged values, STATUS bit0=0, frames_cnt=1.
- Write CTRL=0x5 mid-frame -> isp_en=1 and params commit one cycle later without frame_start; CTRL reads 0x1.
- UPD_REQ write coincident with frame_start -> no commit; commit on the following frame_start.
- 65536 frame_start pulses with FCNT_W=16 -> frames_cnt wraps to 0.
- With ISP_PARAM_BYTE_WR_EN defined: STG1=0x23498701, then byte write 0xFF to 0x0A -> STG1=0x23FF8701. With the macro undefined, the same transfer gives STG1=HWDATA.

Source files
------------

// File: rtl/isp_param_ahb_slave_if.sv
// AHB-Lite bus bundle between the system interconnect and the ISP parameter slave.
// Carries address/control, write data and the slave response.
// The master modport drives requests; the slave modport drives the response.
interface isp_param_ahb_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/isp_param_ahb_slave.sv
// ISP run-time parameter registers: software writes staging words, which are
// committed to the active outputs on a frame boundary (or on a forced commit).
// Zero wait states, always OKAY; sub-word write lanes enabled by ISP_PARAM_BYTE_WR_EN.
module isp_param_ahb_slave #(
  parameter int ADDR_W = 8,
  parameter int FCNT_W = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  isp_param_ahb_slave_if.slave  ahb,
  input  logic                  frame_start,
  output logic                  isp_en,
  output logic [31:0]           param0,
  output logic [31:0]           param1,
  output logic [31:0]           param2,
  output logic [FCNT_W-1:0]     frames_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, COMMIT = 2'd2} state_t;

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] IDX_CTRL   = IW'(0);
  localparam logic [IW-1:0] IDX_STG0   = IW'(1);
  localparam logic [IW-1:0] IDX_STG1   = IW'(2);
  localparam logic [IW-1:0] IDX_STG2   = IW'(3);
  localparam logic [IW-1:0] IDX_STATUS = IW'(4);
  localparam logic [IW-1:0] IDX_ACT0   = IW'(5);

  state_t          state;
  logic            dp_vld;
  logic            dp_write;
  logic [IW-1:0]   dp_idx;
  logic [31:0]     wmask;
  logic [31:0]     stg0, stg1, stg2;
  logic [31:0]     rdata;
  logic [15:0]     fcnt16;
  logic            accept, wr_en, rd_en, ctrl_wr, force_wr, upd_wr, pending;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign accept   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign wr_en    = dp_vld & dp_write;
  assign rd_en    = dp_vld & ~dp_write;
  assign ctrl_wr  = wr_en & (dp_idx == IDX_CTRL);
  assign force_wr = ctrl_wr & wmask[2] & ahb.HWDATA[2];
  assign upd_wr   = ctrl_wr & wmask[1] & ahb.HWDATA[1];
  assign pending  = (state == PENDING);
  assign fcnt16   = 16'(frames_cnt);

  // Address phase capture: remember what the upcoming data phase is about.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
    end else if (ahb.HREADY) begin
      dp_vld   <= accept;
      dp_write <= ahb.HWRITE;
      dp_idx   <= ahb.HADDR[ADDR_W-1:2];
    end
  end

`ifdef ISP_PARAM_BYTE_WR_EN
  logic [1:0] dp_lane;
  logic [2:0] dp_size;
  logic       unused_bits;

  // Byte-lane position and size of the data phase, for sub-word writes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_lane <= 2'b00;
      dp_size <= 3'd0;
    end else if (ahb.HREADY) begin
      dp_lane <= ahb.HADDR[1:0];
      dp_size <= ahb.HSIZE;
    end
  end

  // Little-endian lane mask: byte, halfword, or full word for anything larger.
  always_comb begin
    wmask = '0;
    case (dp_size)
      3'd0:    wmask[{dp_lane, 3'b000} +: 8] = 8'hFF;
      3'd1:    wmask[{dp_lane[1], 4'b0000} +: 16] = 16'hFFFF;
      default: wmask = '1;
    endcase
  end

  assign unused_bits = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDR_W]};
`else
  logic unused_bits;

  assign wmask = '1;
  assign unused_bits = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDR_W], ahb.HADDR[1:0], ahb.HSIZE};
`endif

  // Software-visible registers written at the edge closing a write data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      isp_en <= 1'b0;
      stg0   <= '0;
      stg1   <= '0;
      stg2   <= '0;
    end else if (wr_en) begin
      case (dp_idx)
        IDX_CTRL: if (wmask[0]) isp_en <= ahb.HWDATA[0];
        IDX_STG0: stg0 <= merge(stg0, ahb.HWDATA, wmask);
        IDX_STG1: stg1 <= merge(stg1, ahb.HWDATA, wmask);
        IDX_STG2: stg2 <= merge(stg2, ahb.HWDATA, wmask);
        default:  ;
      endcase
    end
  end

  // Commit FSM: a forced commit beats an arm request, which beats frame_start.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      param0 <= '0;
      param1 <= '0;
      param2 <= '0;
    end else begin
      if (state == COMMIT) begin
        param0 <= stg0;
        param1 <= stg1;
        param2 <= stg2;
      end
      if (force_wr) begin
        state <= COMMIT;
      end else if (upd_wr) begin
        state <= PENDING;
      end else begin
        case (state)
          PENDING: if (frame_start) state <= COMMIT;
          COMMIT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Frame counter, wrapping naturally at its width.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frames_cnt <= '0;
    end else if (frame_start) begin
      frames_cnt <= frames_cnt + 1'b1;
    end
  end

  // Read mux driven straight from the registered data-phase address.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (dp_idx)
        IDX_CTRL:   rdata = {30'b0, pending, isp_en};
        IDX_STG0:   rdata = stg0;
        IDX_STG1:   rdata = stg1;
        IDX_STG2:   rdata = stg2;
        IDX_STATUS: rdata = {fcnt16, 15'b0, pending};
        IDX_ACT0:   rdata = param0;
        default:    rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

endmodule

// File: tb/tb_isp_param_ahb_slave.sv
// Directed bench for the ISP parameter slave with a register-level reference model
// checked every cycle, plus literal expectations at key points.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_isp_param_ahb_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        frame_start;
  logic        isp_en;
  logic [31:0] param0, param1, param2;
  logic [15:0] frames_cnt;
  logic        started = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  isp_param_ahb_slave_if ahb();

  isp_param_ahb_slave #(.ADDR_W(8), .FCNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(ahb), .frame_start(frame_start),
    .isp_en(isp_en), .param0(param0), .param1(param1), .param2(param2),
    .frames_cnt(frames_cnt)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- reference model (register level) ----------------
  logic        m_en;
  logic [31:0] m_stg [3];
  logic [31:0] m_par [3];
  logic        m_pending;
  logic        m_due;
  logic [15:0] m_fcnt;
  logic        ph_vld, ph_wr;
  logic [31:0] ph_addr;
  logic [2:0]  ph_size;

  function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
`ifdef ISP_PARAM_BYTE_WR_EN
    if (sz == 3'd0) return 4'b0001 << a;
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
`else
    return (sz == 3'd7 && a == 2'd3) ? 4'b1111 : 4'b1111;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[7:0] & 8'hFC)
      8'h00:   return {30'b0, m_pending, m_en};
      8'h04:   return m_stg[0];
      8'h08:   return m_stg[1];
      8'h0C:   return m_stg[2];
      8'h10:   return {m_fcnt, 15'b0, m_pending};
      8'h14:   return m_par[0];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_en = 0; m_pending = 0; m_due = 0; m_fcnt = 0;
      for (int i = 0; i < 3; i++) begin m_stg[i] = 0; m_par[i] = 0; end
      ph_vld = 0; ph_wr = 0; ph_addr = 0; ph_size = 0;
    end else begin
      logic [3:0] be;
      logic       frc, upd, due_n;
      int         k;
      if (m_due) for (int i = 0; i < 3; i++) m_par[i] = m_stg[i];
      frc = 0; upd = 0;
      if (ph_vld && ph_wr) begin
        be = lanes(ph_size, ph_addr[1:0]);
        case (ph_addr[7:0] & 8'hFC)
          8'h00: if (be[0]) begin
            m_en = ahb.HWDATA[0]; upd = ahb.HWDATA[1]; frc = ahb.HWDATA[2];
          end
          8'h04, 8'h08, 8'h0C: begin
            k = (ph_addr[7:0] >> 2) - 1;
            for (int b = 0; b < 4; b++)
              if (be[b]) m_stg[k][b*8 +: 8] = ahb.HWDATA[b*8 +: 8];
          end
          default: ;
        endcase
      end
      due_n = frc || (!upd && m_pending && frame_start);
      if (frc) m_pending = 0;
      else if (upd) m_pending = 1;
      else if (m_pending && frame_start) m_pending = 0;
      m_due = due_n;
      if (frame_start) m_fcnt = m_fcnt + 16'd1;
      if (ahb.HREADY) begin
        ph_vld  = ahb.HSEL & ahb.HTRANS[1];
        ph_wr   = ahb.HWRITE;
        ph_addr = ahb.HADDR;
        ph_size = ahb.HSIZE;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge HCLK) begin
    if (started && HRESETn) begin
      logic [31:0] exp_rd;
      exp_rd = (ph_vld && !ph_wr) ? model_read(ph_addr) : 32'h0;
      check("cycle_outputs",
            {isp_en, param0, param1, param2, frames_cnt, ahb.HRDATA, ahb.HREADYOUT, ahb.HRESP},
            {m_en, m_par[0], m_par[1], m_par[2], m_fcnt, exp_rd, 1'b1, 1'b0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] sz);
    ahb.HSEL = 1; ahb.HTRANS = 2'b10; ahb.HWRITE = w; ahb.HADDR = a; ahb.HSIZE = sz;
  endtask

  task automatic bus_idle();
    ahb.HSEL = 0; ahb.HTRANS = 2'b00; ahb.HWRITE = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                    input logic fs);
    addr_phase(1'b1, a, sz);
    step();
    bus_idle();
    ahb.HWDATA = d; frame_start = fs;
    step();
    frame_start = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_phase(1'b0, a, 3'd2);
    step();
    bus_idle();
    @(negedge HCLK);
    d = ahb.HRDATA;
    step();
  endtask

  task automatic pipe2(input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic w2, input logic [31:0] a2, input logic [31:0] d2,
                       output logic [31:0] r2);
    addr_phase(w1, a1, 3'd2);
    step();
    ahb.HWDATA = d1;
    addr_phase(w2, a2, 3'd2);
    step();
    bus_idle();
    ahb.HWDATA = d2;
    @(negedge HCLK);
    r2 = ahb.HRDATA;
    step();
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    step();
    frame_start = 0;
  endtask

  logic [31:0] r;
  logic [31:0] byte_exp;

  initial begin
    ahb.HSEL = 0; ahb.HADDR = 0; ahb.HTRANS = 0; ahb.HWRITE = 0; ahb.HSIZE = 3'd2;
    ahb.HWDATA = 0; ahb.HREADY = 1; frame_start = 0; HRESETn = 0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1; started = 1;

    // Reset state
    check("rst_outputs", {isp_en, param0, param1, param2, frames_cnt}, '0);
    for (int a = 0; a <= 'h14; a += 4) begin
      rd(32'(a), r);
      check("rst_read", r, 32'h0);
    end

    // Staged commit on frame boundary
    wr(32'h04, 32'h00000001, 3'd2, 1'b0);
    wr(32'h08, 32'h23498701, 3'd2, 1'b0);
    wr(32'h0C, 32'hAB9C8F00, 3'd2, 1'b0);
    wr(32'h00, 32'h00000002, 3'd2, 1'b0);
    step(); step();
    check("no_commit_yet", {param0, param1, param2}, '0);
    rd(32'h10, r);
    check("status_pending", r, 32'h00000001);
    pulse_frame();
    step();
    check("commit_params", {param0, param1, param2}, {32'h1, 32'h23498701, 32'hAB9C8F00});
    rd(32'h10, r);
    check("status_after_commit", r, 32'h00010000);
    rd(32'h14, r);
    check("act0", r, 32'h00000001);

    // Forced commit mid-frame, enable applied immediately
    wr(32'h04, 32'hCAFEF00D, 3'd2, 1'b0);
    wr(32'h00, 32'h00000005, 3'd2, 1'b0);
    check("force_en_now", {isp_en, param0}, {1'b1, 32'h1});
    step();
    check("force_commit", param0, 32'hCAFEF00D);
    rd(32'h00, r);
    check("ctrl_read", r, 32'h00000001);

    // Arm coincident with frame_start: waits for the next frame
    wr(32'h08, 32'h11112222, 3'd2, 1'b0);
    wr(32'h00, 32'h00000003, 3'd2, 1'b1);
    step(); step(); step();
    check("arm_only", param1, 32'h23498701);
    rd(32'h10, r);
    check("status_armed", r, 32'h00020001);
    pulse_frame();
    step();
    check("late_commit", param1, 32'h11112222);
    rd(32'h10, r);
    check("status_frame3", r, 32'h00030000);

    // Read directly after write to the same register
    pipe2(1'b1, 32'h0C, 32'h5A5A1234, 1'b0, 32'h0C, 32'h0, r);
    check("wr_then_rd", r, 32'h5A5A1234);

    // Unmapped and decode-ignored address bits
    wr(32'h18, 32'hFFFFFFFF, 3'd2, 1'b0);
    rd(32'h18, r);
    check("unmapped_rd", r, 32'h0);
    rd(32'h05, r);
    check("addr_lsb_ignored", r, 32'hCAFEF00D);
    rd(32'h104, r);
    check("addr_msb_ignored", r, 32'hCAFEF00D);

    // STG write in the commit cycle: old value committed, new stays staged
    wr(32'h04, 32'h00000001, 3'd2, 1'b0);
    pipe2(1'b1, 32'h00, 32'h00000005, 1'b1, 32'h04, 32'h77777777, r);
    step();
    check("commit_old_stg", {param0, param2}, {32'h1, 32'h5A5A1234});
    rd(32'h04, r);
    check("new_stg_kept", r, 32'h77777777);

    // Sub-word write
    wr(32'h08, 32'h23498701, 3'd2, 1'b0);
    wr(32'h0A, 32'h00FF0000, 3'd0, 1'b0);
    rd(32'h08, r);
`ifdef ISP_PARAM_BYTE_WR_EN
    byte_exp = 32'h23FF8701;
`else
    byte_exp = 32'h00FF0000;
`endif
    check("byte_write", r, byte_exp);

    // Frame counter wrap: 3 frames so far, 65533 more gives 0
    frame_start = 1;
    repeat (65533) step();
    frame_start = 0;
    check("fcnt_wrap", frames_cnt, 16'h0000);
    check("idle_frames_no_commit", param1, 32'h11112222);

    // Reset mid-transfer with a commit armed
    wr(32'h00, 32'h00000003, 3'd2, 1'b0);
    addr_phase(1'b1, 32'h0C, 3'd2);
    step();
    bus_idle();
    ahb.HWDATA = 32'hDEADBEEF;
    #3 HRESETn = 0;
    #1 check("async_clear", {isp_en, param0, param1, param2, frames_cnt}, '0);
    @(posedge HCLK); #1 HRESETn = 1;
    pulse_frame();
    step();
    check("no_commit_after_rst", {param0, param1, param2, frames_cnt}, {96'h0, 16'h1});
    rd(32'h0C, r);
    check("stg_cleared", r, 32'h0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
